// File: rtl/ift_taint_sink_monitor.sv
// Taint sink monitor: flags samples whose label hits a forbidden-label mask,
// counts violations and hands the first pending violation to a consumer over valid/ready.
module ift_taint_sink_monitor #(
  parameter int WIDTH   = 2,
  parameter int TAINT_W = 32,
  parameter int CNT_W   = 8
) (
  input  logic               CLK,
  input  logic               ARST,
  input  logic               ARM,
  input  logic [TAINT_W-1:0] MASK,
  input  logic [WIDTH-1:0]   D,
  input  logic [TAINT_W-1:0] D_t,
  input  logic               D_VALID,
  output logic               REP_VALID,
  input  logic               REP_READY,
  output logic [TAINT_W-1:0] REP_LABEL,
  output logic [WIDTH-1:0]   REP_DATA,
  output logic [TAINT_W-1:0] ACC_LABEL,
  output logic [CNT_W-1:0]   VIOL_CNT,
  output logic [1:0]         STATE
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    REPORT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [TAINT_W-1:0] mask_q, mask_d;
  logic [TAINT_W-1:0] label_q, label_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [TAINT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               valid_q;

  logic [TAINT_W-1:0] hit_label;
  logic               d_known, hit;

  // Unknown data carries no taint, mirroring the tracked storage cells.
  assign d_known   = (^D !== 1'bx);
  assign hit_label = D_t & mask_q;
  assign hit       = D_VALID && d_known && (hit_label != '0) &&
                     (state_q == ARMED || state_q == REPORT);
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d = state_q;
    mask_d  = mask_q;
    label_d = label_q;
    data_d  = data_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (ARM) begin
          state_d = ARMED;
          mask_d  = MASK;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      ARMED: begin
        if (!ARM) begin
          state_d = IDLE;
        end else if (hit) begin
          state_d = REPORT;
          label_d = hit_label;
          data_d  = D;
          cnt_d   = cnt_inc;
          acc_d   = acc_q | hit_label;
        end
      end
      REPORT: begin
        if (hit) begin
          cnt_d = cnt_inc;
          acc_d = acc_q | hit_label;
        end
        // REP_VALID is always high here, so REP_READY alone completes the handshake.
        if (REP_READY) begin
          if (hit) begin
            label_d = hit_label;
            data_d  = D;
          end else begin
            state_d = ARM ? ARMED : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: synchronous reset checked first so it overrides all inputs; state uses non-blocking assignments.
    if (ARST) begin
      state_q <= IDLE;
      mask_q  <= '0;
      label_q <= '0;
      data_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      label_q <= label_d;
      data_q  <= data_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      valid_q <= (state_d == REPORT);
    end
  end

  assign REP_VALID = valid_q;
  assign REP_LABEL = label_q;
  assign REP_DATA  = data_q;
  assign ACC_LABEL = acc_q;
  assign VIOL_CNT  = cnt_q;
  assign STATE     = state_q;

endmodule

// File: tb/tb_ift_taint_sink_monitor.sv
// Directed bench for ift_taint_sink_monitor: a behavioural model pushes expected
// outputs to a scoreboard queue as each cycle is driven; they are popped after the edge.
module tb_ift_taint_sink_monitor;

  localparam int WIDTH   = 2;
  localparam int TAINT_W = 32;

  typedef struct {
    logic [1:0]         state;
    logic               valid;
    logic [TAINT_W-1:0] label;
    logic [WIDTH-1:0]   data;
    logic [TAINT_W-1:0] acc;
    logic [7:0]         cnt8;
    logic [1:0]         cnt2;
  } exp_t;

  logic               clk = 1'b0;
  logic               arst, arm, d_valid, rep_ready;
  logic [TAINT_W-1:0] mask, d_t;
  logic [WIDTH-1:0]   d;

  logic               rep_valid_a, rep_valid_b;
  logic [TAINT_W-1:0] rep_label_a, rep_label_b, acc_a, acc_b;
  logic [WIDTH-1:0]   rep_data_a, rep_data_b;
  logic [7:0]         cnt_a;
  logic [1:0]         cnt_b, state_a, state_b;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t sb[$];

  // Reference model state
  logic [1:0]         m_state = 2'd0;
  logic [TAINT_W-1:0] m_mask = '0, m_label = '0, m_acc = '0;
  logic [WIDTH-1:0]   m_data = '0;
  logic [7:0]         m_cnt8 = '0;
  logic [1:0]         m_cnt2 = '0;

  always #5 clk = ~clk;

  ift_taint_sink_monitor #(.WIDTH(WIDTH), .TAINT_W(TAINT_W), .CNT_W(8)) dut_a (
    .CLK(clk), .ARST(arst), .ARM(arm), .MASK(mask), .D(d), .D_t(d_t),
    .D_VALID(d_valid), .REP_VALID(rep_valid_a), .REP_READY(rep_ready),
    .REP_LABEL(rep_label_a), .REP_DATA(rep_data_a), .ACC_LABEL(acc_a),
    .VIOL_CNT(cnt_a), .STATE(state_a)
  );

  ift_taint_sink_monitor #(.WIDTH(WIDTH), .TAINT_W(TAINT_W), .CNT_W(2)) dut_b (
    .CLK(clk), .ARST(arst), .ARM(arm), .MASK(mask), .D(d), .D_t(d_t),
    .D_VALID(d_valid), .REP_VALID(rep_valid_b), .REP_READY(rep_ready),
    .REP_LABEL(rep_label_b), .REP_DATA(rep_data_b), .ACC_LABEL(acc_b),
    .VIOL_CNT(cnt_b), .STATE(state_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_step();
    logic [TAINT_W-1:0] hl;
    logic               h;
    hl = d_t & m_mask;
    h  = d_valid && (^d !== 1'bx) && (hl != '0) && (m_state == 2'd1 || m_state == 2'd2);
    if (arst) begin
      m_state = 2'd0; m_mask = '0; m_label = '0; m_data = '0;
      m_acc = '0; m_cnt8 = '0; m_cnt2 = '0;
    end else begin
      case (m_state)
        2'd0: if (arm) begin
          m_state = 2'd1; m_mask = mask; m_cnt8 = '0; m_cnt2 = '0; m_acc = '0;
        end
        2'd1: if (!arm) m_state = 2'd0;
              else if (h) begin
                m_state = 2'd2; m_label = hl; m_data = d;
              end
        default: begin
          if (rep_ready && h) begin
            m_label = hl; m_data = d;
          end else if (rep_ready) begin
            m_state = arm ? 2'd1 : 2'd0;
          end
        end
      endcase
      if (h && !(m_state == 2'd0) && !(m_state == 2'd1 && !arm)) begin
        if (m_cnt8 != 8'hFF) m_cnt8 = m_cnt8 + 8'd1;
        if (m_cnt2 != 2'd3)  m_cnt2 = m_cnt2 + 2'd1;
        m_acc = m_acc | hl;
      end
    end
  endtask

  // Drive one cycle (inputs already set), push the expectation, pop and compare after the edge.
  task automatic step(input string tag);
    exp_t e;
    model_step();
    e.state = m_state; e.valid = (m_state == 2'd2); e.label = m_label;
    e.data = m_data; e.acc = m_acc; e.cnt8 = m_cnt8; e.cnt2 = m_cnt2;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, ".state"},   32'(state_a),     32'(e.state));
    check({tag, ".valid"},   32'(rep_valid_a), 32'(e.valid));
    check({tag, ".label"},   rep_label_a,      e.label);
    check({tag, ".data"},    32'(rep_data_a),  32'(e.data));
    check({tag, ".acc"},     acc_a,            e.acc);
    check({tag, ".cnt8"},    32'(cnt_a),       32'(e.cnt8));
    check({tag, ".cnt2"},    32'(cnt_b),       32'(e.cnt2));
    check({tag, ".b_state"}, 32'(state_b),     32'(e.state));
    @(negedge clk);
  endtask

  task automatic drive(input logic a, input logic [TAINT_W-1:0] m, input logic [WIDTH-1:0] dd,
                       input logic [TAINT_W-1:0] dt, input logic dv, input logic rr);
    arm = a; mask = m; d = dd; d_t = dt; d_valid = dv; rep_ready = rr;
  endtask

  initial begin
    logic [WIDTH-1:0] dx;
    dx = 2'bx1;
    arst = 1'b1;
    drive(0, '0, '0, '0, 0, 0);
    @(negedge clk);
    step("reset0");
    step("reset1");
    arst = 1'b0;

    // Samples in IDLE are ignored
    drive(0, 32'h4, 2'd2, 32'h4, 1, 0);        step("idle_ignore");
    drive(1, 32'h4, 2'd0, 32'h0, 0, 0);        step("arm");
    check("arm_state_lit", 32'(state_a), 32'd1);

    drive(1, 32'hFF, 2'd2, 32'h6, 1, 0);       step("hit1");
    check("hit1_label_lit", rep_label_a, 32'h4);
    check("hit1_data_lit", 32'(rep_data_a), 32'd2);
    drive(1, 32'hFF, 2'd3, 32'h5, 1, 0);       step("hit2");
    drive(1, 32'hFF, 2'd3, 32'h5, 1, 0);       step("hit3");
    check("hit3_cnt_lit", 32'(cnt_a), 32'd3);
    check("hit3_label_lit", rep_label_a, 32'h4);

    drive(1, 32'h0, 2'd1, 32'h4, 1, 1);        step("hs_hit");
    check("hs_hit_data_lit", 32'(rep_data_a), 32'd1);
    drive(1, 32'h0, 2'd0, 32'h4, 0, 1);        step("hs_nohit");

    // X data carries no taint; the model judges knownness of what was actually driven
    drive(1, 32'h0, dx, 32'hFFFF_FFFF, 1, 0);  step("xdata");
    drive(1, 32'h0, 2'd0, 32'h0, 0, 1);        step("x_drain");

    for (int i = 0; i < 6; i++) begin
      drive(1, 32'h0, 2'(i), 32'($urandom) | 32'h4, 1, 0);
      step("sat");
    end
    check("sat_cnt2_lit", 32'(cnt_b), 32'd3);

    // ARM drop in REPORT holds the report until accepted
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'h0, 2'd3, 32'h4, 1, 0);      step("disarm_hold");
    end
    drive(0, 32'h0, 2'd0, 32'h0, 0, 1);        step("disarm_accept");
    check("disarm_idle_lit", 32'(state_a), 32'd0);

    // Mask is frozen while armed
    drive(1, 32'h1, 2'd0, 32'h0, 0, 0);        step("rearm");
    drive(1, 32'h2, 2'd1, 32'h2, 1, 0);        step("mask_frozen");
    drive(0, 32'h2, 2'd1, 32'h1, 1, 0);        step("disarm_beats_hit");
    drive(1, 32'h30, 2'd0, 32'h0, 0, 0);       step("rearm2");
    drive(1, 32'h30, 2'd2, 32'h10, 1, 0);      step("hit_pre_rst");

    arst = 1'b1;
    drive(1, 32'h30, 2'd3, 32'h20, 1, 0);      step("rst_in_report");
    check("rst_valid_lit", 32'(rep_valid_a), 32'd0);
    arst = 1'b0;
    drive(0, '0, '0, '0, 0, 0);                step("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
